// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared state encoding and width helper for the UART transmit arbiter.
package uart_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} arb_state_t;

    // Index width that never collapses to zero bits, so a single requester still gets a 1-bit id.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req_i  - request vector
//   last_i - index of the previous grant; scanning starts just after it
//   lock_i - restrict eligibility to the previous owner (last_i)
//   gnt_o  - one-hot grant, zero when nothing is eligible
//   idx_o  - encoded grant index (holds last_i when nothing is eligible)
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [id_w(N)-1:0]   last_i,
    input  logic                 lock_i,
    output logic [N-1:0]         gnt_o,
    output logic [id_w(N)-1:0]   idx_o
);

    localparam int W = id_w(N);

    logic [N-1:0] elig;
    logic [W-1:0] k;

    assign elig = lock_i ? (req_i & (N'(1) << last_i)) : req_i;

    // Scan from the farthest candidate down to the nearest, so the nearest eligible one wins.
    always_comb begin
        gnt_o = '0;
        idx_o = last_i;
        k     = '0;
        for (int i = N; i >= 1; i--) begin
            k = W'((int'(last_i) + i) % N);
            if (elig[k]) begin
                gnt_o = N'(1) << k;
                idx_o = k;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among NUM_REQ byte requesters.
//   i_clk, i_rst          - clock, asynchronous active-high reset
//   i_req_valid/_byte/_last, o_req_ready - per-requester byte handshake
//   o_tx_dv, o_tx_byte, i_tx_active, i_tx_done - transmitter handshake
//   o_grant_id            - current/last owner
//   o_busy                - byte in flight or packet lock held
//   o_timeout             - one-cycle pulse when the watchdog aborts a byte
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int TIMEOUT_CLKS = 4096,
    parameter int LOCK_PACKETS = 1
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [NUM_REQ-1:0]          i_req_valid,
    input  logic [NUM_REQ*8-1:0]        i_req_byte,
    input  logic [NUM_REQ-1:0]          i_req_last,
    output logic [NUM_REQ-1:0]          o_req_ready,
    output logic                        o_tx_dv,
    output logic [7:0]                  o_tx_byte,
    input  logic                        i_tx_active,
    input  logic                        i_tx_done,
    output logic [id_w(NUM_REQ)-1:0]    o_grant_id,
    output logic                        o_busy,
    output logic                        o_timeout
);

    localparam int GW = id_w(NUM_REQ);
    localparam int WW = id_w(TIMEOUT_CLKS);

    arb_state_t    state_q, state_d;
    logic [7:0]    byte_q, byte_d;
    logic [GW-1:0] gid_q, gid_d;
    logic          lock_q, lock_d;
    logic [WW-1:0] wd_q, wd_d;
    logic          to_q, to_d;

    logic [NUM_REQ-1:0] gnt;
    logic [GW-1:0]      idx;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req_i  (i_req_valid),
        .last_i (gid_q),
        .lock_i (lock_q),
        .gnt_o  (gnt),
        .idx_o  (idx)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            byte_q  <= '0;
            gid_q   <= GW'(NUM_REQ - 1);
            lock_q  <= 1'b0;
            wd_q    <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            byte_q  <= byte_d;
            gid_q   <= gid_d;
            lock_q  <= lock_d;
            wd_q    <= wd_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        byte_d      = byte_q;
        gid_d       = gid_q;
        lock_d      = lock_q;
        wd_d        = wd_q;
        to_d        = 1'b0;
        o_req_ready = '0;
        case (state_q)
            IDLE: begin
                if (!i_tx_active && |gnt) begin
                    o_req_ready = gnt;
                    byte_d      = i_req_byte[{idx, 3'b000} +: 8];
                    gid_d       = idx;
                    lock_d      = (LOCK_PACKETS != 0) && !i_req_last[idx];
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT_DONE;
                wd_d    = '0;
            end
            WAIT_DONE: begin
                // done takes priority over a simultaneous watchdog expiry
                if (i_tx_done) begin
                    state_d = IDLE;
                end else if (wd_q == WW'(TIMEOUT_CLKS - 1)) begin
                    state_d = IDLE;
                    to_d    = 1'b1;
                    lock_d  = 1'b0;
                end else begin
                    wd_d = (&wd_q) ? wd_q : wd_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_tx_dv    = (state_q == ISSUE);
    assign o_tx_byte  = byte_q;
    assign o_grant_id = gid_q;
    assign o_busy     = (state_q != IDLE) || lock_q;
    assign o_timeout  = to_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

    localparam int TO = 40;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] vld[2], last[2], rdy[2], fire[2];
    logic [31:0] byt[2];
    logic       dv[2], act[2], done[2], busy[2], tmo[2];
    logic [7:0] txb[2];
    logic [1:0] gid[2];

    logic [8:0] rq[8][$];
    logic [9:0] sb[2][$];
    logic [9:0] exp_v;
    int dly[2], cnt[2];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CLKS(TO), .LOCK_PACKETS(1)) dut (
        .i_clk(clk), .i_rst(rst), .i_req_valid(vld[0]), .i_req_byte(byt[0]), .i_req_last(last[0]),
        .o_req_ready(rdy[0]), .o_tx_dv(dv[0]), .o_tx_byte(txb[0]), .i_tx_active(act[0]),
        .i_tx_done(done[0]), .o_grant_id(gid[0]), .o_busy(busy[0]), .o_timeout(tmo[0])
    );

    uart_tx_arbiter #(.NUM_REQ(4), .TIMEOUT_CLKS(TO), .LOCK_PACKETS(0)) dut_nolock (
        .i_clk(clk), .i_rst(rst), .i_req_valid(vld[1]), .i_req_byte(byt[1]), .i_req_last(last[1]),
        .o_req_ready(rdy[1]), .o_tx_dv(dv[1]), .o_tx_byte(txb[1]), .i_tx_active(act[1]),
        .i_tx_done(done[1]), .o_grant_id(gid[1]), .o_busy(busy[1]), .o_timeout(tmo[1])
    );

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) fire[d] = vld[d] & rdy[d];
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            done[d] = 1'b0;
            if (rst) cnt[d] = 0;
            else if (dv[d]) cnt[d] = dly[d];
            else if (cnt[d] > 0) begin
                cnt[d]--;
                if (cnt[d] == 0) done[d] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rdy[d] != 4'b0) begin
                checks++;
                if ($countones(rdy[d]) != 1 || (rdy[d] & ~vld[d]) != 4'b0) begin
                    errors++;
                    $display("FAIL ready_onehot dut%0d: ready=%b valid=%b, want one-hot within valid", d, rdy[d], vld[d]);
                end
            end
            if (dv[d]) begin
                checks++;
                if (sb[d].size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_issue dut%0d: id=%0d byte=%h, want no issue", d, gid[d], txb[d]);
                end else begin
                    exp_v = sb[d].pop_front();
                    if ({gid[d], txb[d]} !== exp_v) begin
                        errors++;
                        $display("FAIL issue_order dut%0d: id=%0d byte=%h, want id=%0d byte=%h",
                                 d, gid[d], txb[d], exp_v[9:8], exp_v[7:0]);
                    end
                end
            end
            for (int k = 0; k < 4; k++) begin
                if (fire[d][k] && rq[d*4+k].size() != 0) void'(rq[d*4+k].pop_front());
                vld[d][k] = rq[d*4+k].size() != 0;
                {last[d][k], byt[d][8*k +: 8]} = vld[d][k] ? rq[d*4+k][0] : 9'h0;
            end
            fire[d] = 4'b0;
        end
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic rq_push(input int d, input int k, input logic [7:0] b, input logic l);
        rq[d*4+k].push_back({l, b});
    endtask

    task automatic exp_push(input int d, input int k, input logic [7:0] b);
        sb[d].push_back({2'(k), b});
    endtask

    task automatic wait_idle(input int d);
        int n = 0;
        bit pend;
        do begin
            tick;
            n++;
            pend = busy[d] || sb[d].size() != 0;
            for (int k = 0; k < 4; k++) pend |= rq[d*4+k].size() != 0;
        end while (pend && n < 3000);
        checks++;
        if (pend) begin
            errors++;
            $display("FAIL idle_timeout dut%0d: still busy after %0d cycles, want idle", d, n);
        end
    endtask

    task automatic wait_dv(input int d);
        int n = 0;
        while (!dv[d] && n < 200) begin
            tick;
            n++;
        end
        checks++;
        if (!dv[d]) begin
            errors++;
            $display("FAIL dv_wait dut%0d: no o_tx_dv within %0d cycles", d, n);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) tick;
        for (int d = 0; d < 2; d++) begin
            checks += 6;
            if (rdy[d] !== 4'b0) begin errors++; $display("FAIL reset_ready dut%0d: %b want 0000", d, rdy[d]); end
            if (dv[d] !== 1'b0) begin errors++; $display("FAIL reset_dv dut%0d: %b want 0", d, dv[d]); end
            if (txb[d] !== 8'h00) begin errors++; $display("FAIL reset_byte dut%0d: %h want 00", d, txb[d]); end
            if (gid[d] !== 2'd3) begin errors++; $display("FAIL reset_gid dut%0d: %0d want 3", d, gid[d]); end
            if (busy[d] !== 1'b0) begin errors++; $display("FAIL reset_busy dut%0d: %b want 0", d, busy[d]); end
            if (tmo[d] !== 1'b0) begin errors++; $display("FAIL reset_timeout dut%0d: %b want 0", d, tmo[d]); end
        end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_rr;
        rq_push(0, 0, 8'h10, 1); rq_push(0, 1, 8'h11, 1); rq_push(0, 3, 8'h13, 1);
        exp_push(0, 0, 8'h10); exp_push(0, 1, 8'h11); exp_push(0, 3, 8'h13);
        wait_idle(0);
        rq_push(0, 3, 8'h23, 1); rq_push(0, 0, 8'h20, 1);
        exp_push(0, 0, 8'h20); exp_push(0, 3, 8'h23);
        wait_idle(0);
    endtask

    task automatic test_lock;
        rq_push(0, 0, 8'h00, 1); exp_push(0, 0, 8'h00);
        wait_idle(0);
        rq_push(0, 1, 8'h48, 0); rq_push(0, 1, 8'h49, 0); rq_push(0, 1, 8'h0A, 1);
        rq_push(0, 0, 8'h55, 1);
        exp_push(0, 1, 8'h48); exp_push(0, 1, 8'h49); exp_push(0, 1, 8'h0A); exp_push(0, 0, 8'h55);
        wait_idle(0);
    endtask

    task automatic test_nolock;
        rq_push(1, 0, 8'h30, 1); exp_push(1, 0, 8'h30);
        wait_idle(1);
        rq_push(1, 1, 8'h48, 0); rq_push(1, 1, 8'h49, 0); rq_push(1, 1, 8'h0A, 1);
        rq_push(1, 0, 8'h61, 0); rq_push(1, 0, 8'h62, 0); rq_push(1, 0, 8'h63, 1);
        exp_push(1, 1, 8'h48); exp_push(1, 0, 8'h61); exp_push(1, 1, 8'h49);
        exp_push(1, 0, 8'h62); exp_push(1, 1, 8'h0A); exp_push(1, 0, 8'h63);
        wait_idle(1);
    endtask

    task automatic test_active;
        act[0] = 1'b1;
        rq_push(0, 1, 8'h31, 1);
        repeat (6) begin
            tick;
            checks++;
            if (rdy[0] !== 4'b0) begin errors++; $display("FAIL active_block: ready=%b want 0000", rdy[0]); end
        end
        exp_push(0, 1, 8'h31);
        act[0] = 1'b0;
        wait_idle(0);
    endtask

    task automatic test_single;
        int n = 0;
        rq_push(0, 2, 8'h41, 1); exp_push(0, 2, 8'h41);
        do begin tick; n++; end while (!rdy[0][2] && n < 50);
        checks++;
        if (rdy[0] !== 4'b0100) begin errors++; $display("FAIL single_ready: %b want 0100", rdy[0]); end
        tick;
        checks += 3;
        if (rdy[0] !== 4'b0) begin errors++; $display("FAIL single_ready_len: %b want 0000", rdy[0]); end
        if (dv[0] !== 1'b1) begin errors++; $display("FAIL single_dv_latency: %b want 1", dv[0]); end
        if (txb[0] !== 8'h41) begin errors++; $display("FAIL single_byte: %h want 41", txb[0]); end
        tick;
        checks++;
        if (dv[0] !== 1'b0) begin errors++; $display("FAIL single_dv_len: %b want 0", dv[0]); end
        wait_idle(0);
        checks += 2;
        if (gid[0] !== 2'd2) begin errors++; $display("FAIL single_gid: %0d want 2", gid[0]); end
        if (busy[0] !== 1'b0) begin errors++; $display("FAIL single_busy: %b want 0", busy[0]); end
    endtask

    task automatic test_timeout;
        int n = 0;
        bit early = 0;
        dly[0] = -1;
        rq_push(0, 2, 8'h77, 0); exp_push(0, 2, 8'h77);
        wait_dv(0);
        rq_push(0, 1, 8'h71, 1); exp_push(0, 1, 8'h71);
        do begin
            tick;
            n++;
            if (!tmo[0] && rdy[0] != 4'b0) early = 1;
        end while (!tmo[0] && n < TO + 10);
        checks += 2;
        if (n != TO + 1) begin errors++; $display("FAIL timeout_latency: %0d cycles want %0d", n, TO + 1); end
        if (early) begin errors++; $display("FAIL lock_stall: ready seen before timeout, want none"); end
        dly[0] = 3;
        tick;
        checks++;
        if (tmo[0] !== 1'b0) begin errors++; $display("FAIL timeout_pulse_len: %b want 0", tmo[0]); end
        wait_idle(0);
    endtask

    task automatic test_done_expiry;
        bit seen = 0;
        dly[0] = TO;
        rq_push(0, 3, 8'h5A, 1); exp_push(0, 3, 8'h5A);
        repeat (TO + 10) begin
            tick;
            if (tmo[0]) seen = 1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL done_vs_expiry: o_timeout=1 want 0"); end
        wait_idle(0);
        dly[0] = 3;
    endtask

    task automatic test_reset_mid;
        dly[0] = -1;
        rq_push(0, 0, 8'h99, 0); exp_push(0, 0, 8'h99);
        wait_dv(0);
        repeat (3) tick;
        rst = 1'b1;
        #1;
        checks += 6;
        if (rdy[0] !== 4'b0) begin errors++; $display("FAIL midreset_ready: %b want 0000", rdy[0]); end
        if (dv[0] !== 1'b0) begin errors++; $display("FAIL midreset_dv: %b want 0", dv[0]); end
        if (txb[0] !== 8'h00) begin errors++; $display("FAIL midreset_byte: %h want 00", txb[0]); end
        if (gid[0] !== 2'd3) begin errors++; $display("FAIL midreset_gid: %0d want 3", gid[0]); end
        if (busy[0] !== 1'b0) begin errors++; $display("FAIL midreset_busy: %b want 0", busy[0]); end
        if (tmo[0] !== 1'b0) begin errors++; $display("FAIL midreset_timeout: %b want 0", tmo[0]); end
        tick;
        foreach (rq[i]) rq[i].delete();
        sb[0].delete();
        sb[1].delete();
        dly[0] = 3;
        rst = 1'b0;
        rq_push(0, 2, 8'h62, 1); rq_push(0, 0, 8'h60, 1);
        exp_push(0, 0, 8'h60); exp_push(0, 2, 8'h62);
        wait_idle(0);
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            vld[d] = '0; last[d] = '0; byt[d] = '0; fire[d] = '0;
            act[d] = 1'b0; done[d] = 1'b0; dly[d] = 3; cnt[d] = 0;
        end
        dly[1] = 2;
        test_reset;
        test_rr;
        test_lock;
        test_nolock;
        test_active;
        test_single;
        test_timeout;
        test_done_expiry;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
